// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the receive FIFO entry layout.
package uart_pkg;
  localparam int UART_DW    = 8;
  localparam int RX_ENTRY_W = UART_DW + 1;

  typedef struct packed {
    logic               frame_err;
    logic [UART_DW-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/rx_idle_timer.sv
// Saturating idle counter; expired holds while the count sits at TIMEOUT_CYC.
module rx_idle_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)                              cnt <= '0;
    else if (run && cnt != CW'(TIMEOUT_CYC))     cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == CW'(TIMEOUT_CYC));
endmodule

// File: rtl/rx_fifo.sv
// Receive-side byte FIFO: first-word-fall-through toward uart_ctrl, sticky overrun,
// and an interrupt on fill threshold, idle timeout or overrun.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int THRESH      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [UART_DW-1:0]         rx_uart_data,
  input  logic                       rx_uart_valid,
  input  logic                       rx_uart_frame_err,
  output logic                       rx_uart_clear,
  output logic [UART_DW-1:0]         rx_ctrl_data,
  output logic                       rx_ctrl_frame_err,
  output logic                       rx_ctrl_valid,
  input  logic                       rx_ctrl_rd,
  output logic [$clog2(DEPTH):0]     rx_ctrl_level,
  output logic                       rx_ctrl_overrun,
  input  logic                       rx_ctrl_ovr_clr,
  output logic                       rx_ctrl_timeout,
  output logic                       rx_ctrl_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rx_entry_t      mem [DEPTH];
  rx_entry_t      head;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [LW-1:0]  level;
  logic           overrun;
  logic           full, empty, push, pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign pop   = rx_ctrl_rd & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the byte.
  assign push  = rx_uart_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      level         <= '0;
      overrun       <= 1'b0;
      rx_uart_clear <= 1'b0;
    end else begin
      rx_uart_clear <= rx_uart_valid;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (rx_uart_valid && !push) overrun <= 1'b1;
      else if (rx_ctrl_ovr_clr)   overrun <= 1'b0;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_entry_t'({rx_uart_frame_err, rx_uart_data});
  end

  rx_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (push | pop | empty),
    .run     (~empty),
    .expired (rx_ctrl_timeout)
  );

  assign head              = mem[rd_ptr];
  assign rx_ctrl_data      = head.data;
  assign rx_ctrl_frame_err = head.frame_err;
  assign rx_ctrl_valid     = ~empty;
  assign rx_ctrl_level     = level;
  assign rx_ctrl_overrun   = overrun;
  assign rx_ctrl_irq       = (level >= LW'(THRESH)) | rx_ctrl_timeout | overrun;
endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rx_fifo;
  localparam int DEPTH = 8;
  localparam int THRESH = 4;
  localparam int TO = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] u_data;
  logic       u_valid, u_fe, c_rd, c_ovr_clr;
  logic       u_clear, c_fe, c_valid, c_ovr, c_to, c_irq;
  logic [7:0] c_data;
  logic [3:0] c_level;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [8:0] q[$];
  bit         m_ovr, m_clear;
  int         m_cnt;

  always #5 clk = ~clk;

  rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_uart_data(u_data), .rx_uart_valid(u_valid), .rx_uart_frame_err(u_fe),
    .rx_uart_clear(u_clear),
    .rx_ctrl_data(c_data), .rx_ctrl_frame_err(c_fe), .rx_ctrl_valid(c_valid),
    .rx_ctrl_rd(c_rd), .rx_ctrl_level(c_level), .rx_ctrl_overrun(c_ovr),
    .rx_ctrl_ovr_clr(c_ovr_clr), .rx_ctrl_timeout(c_to), .rx_ctrl_irq(c_irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is a queue, timer is a plain saturating integer.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovr = 0; m_cnt = 0; m_clear = 0;
    end else begin
      bit pop, push, was_empty;
      was_empty = (q.size() == 0);
      pop  = c_rd && !was_empty;
      push = u_valid && (q.size() < DEPTH || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({u_fe, u_data});
      if (u_valid && !push) m_ovr = 1;
      else if (c_ovr_clr)   m_ovr = 0;
      if (push || pop || was_empty) m_cnt = 0;
      else if (m_cnt < TO)          m_cnt++;
      m_clear = u_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", c_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("data", c_data, q[0][7:0]);
        chk("frame_err", c_fe, q[0][8]);
      end
      chk("level", c_level, q.size());
      chk("overrun", c_ovr, m_ovr);
      chk("timeout", c_to, m_cnt == TO);
      chk("irq", c_irq, (q.size() >= THRESH) || (m_cnt == TO) || m_ovr);
      chk("uart_clear", u_clear, m_clear);
    end
  end

  // Drive one cycle's inputs, then return at the following negedge with outputs settled.
  task automatic cyc(input bit v, input logic [7:0] d, input bit fe, input bit rd, input bit oc);
    u_valid = v; u_data = d; u_fe = fe; c_rd = rd; c_ovr_clr = oc;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    rst = 1; u_valid = 0; u_data = 0; u_fe = 0; c_rd = 0; c_ovr_clr = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk_en = 1;
    chk("rst_valid", c_valid, 0);
    chk("rst_level", c_level, 0);
    chk("rst_irq", c_irq, 0);
    chk("rst_timeout", c_to, 0);

    // Single push and its one-cycle latency.
    cyc(1, 8'h41, 0, 0, 0);
    chk("t1_valid", c_valid, 1);
    chk("t1_data", c_data, 8'h41);
    chk("t1_level", c_level, 1);
    chk("t1_clear", u_clear, 1);
    idle();
    chk("t1_clear_once", u_clear, 0);
    cyc(0, 8'h00, 0, 1, 0);

    // Fill to DEPTH, irq from THRESH upward, then drain in order.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      chk("t2_irq", c_irq, (i + 1) >= 4);
    end
    chk("t2_level", c_level, 8);
    chk("t2_ovr", c_ovr, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t2_order", c_data, 8'(i));
      cyc(0, 8'h00, 0, 1, 0);
    end
    chk("t2_empty", c_valid, 0);

    // Overrun is sticky and wins over a same-cycle clear.
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    chk("t3_ovr", c_ovr, 1);
    chk("t3_level", c_level, 8);
    cyc(1, 8'hBB, 0, 0, 1);
    chk("t3_ovr_prio", c_ovr, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("t3_ovr_clr", c_ovr, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", c_data, 8'h10 + 8'(i));
      cyc(0, 8'h00, 0, 1, 0);
    end

    // Push while full with a simultaneous pop.
    for (int i = 0; i < 8; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 0);
    cyc(1, 8'h55, 0, 1, 0);
    chk("t4_level", c_level, 8);
    chk("t4_ovr", c_ovr, 0);
    for (int i = 1; i < 8; i++) begin
      chk("t4_order", c_data, 8'h20 + 8'(i));
      cyc(0, 8'h00, 0, 1, 0);
    end
    chk("t4_last", c_data, 8'h55);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t4_empty", c_valid, 0);

    // Idle timeout exactly TO cycles after the push.
    cyc(1, 8'h66, 0, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      idle();
      if (k == TO - 1) chk("t5_not_yet", c_to, 0);
      if (k == TO)     chk("t5_timeout", c_to, 1);
    end
    chk("t5_irq", c_irq, 1);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t5_pop_clr", c_to, 0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t5_rd_empty_lvl", c_level, 0);
    chk("t5_rd_empty_to", c_to, 0);

    // Reset mid-stream discards content; fresh entry shows its own frame_err.
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 1, 0, 0);
    rst = 1;
    cyc(1, 8'h03, 0, 1, 0);
    chk("t6_valid", c_valid, 0);
    chk("t6_level", c_level, 0);
    chk("t6_irq", c_irq, 0);
    chk("t6_clear", u_clear, 0);
    rst = 0;
    cyc(1, 8'h77, 0, 0, 0);
    chk("t6_fe", c_fe, 0);
    chk("t6_data", c_data, 8'h77);

    // Randomized traffic with per-segment push/pop bias and occasional reset.
    for (int seg = 0; seg < 8; seg++) begin
      int pv, pr;
      pv = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int n = 0; n < 400; n++) begin
        rst = ($urandom_range(0, 399) == 0);
        cyc($urandom_range(0, 99) < pv, 8'($urandom), 1'($urandom),
            $urandom_range(0, 99) < pr, $urandom_range(0, 15) == 0);
      end
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
